multi_sel_feeder: RTL

- Upstream byte source for multi_sel; buffers incoming 8-bit operands in a small circular FIFO.
- Presents the oldest entry on d and pops it on each clock edge where multi_sel asserts input_grant.
- Decouples a bursty producer from multi_sel's periodic operand acceptance.
- Flags any grant that arrives while no operand is buffered.

---
 rtl/multi_sel_feeder.sv | 46 ++++
 1 files changed

// File: rtl/multi_sel_feeder.sv
// multi_sel_feeder: circular FIFO that buffers producer bytes and feeds them to multi_sel on input_grant
module multi_sel_feeder #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          input_grant,
    output logic [DW-1:0] d,
    output logic          d_valid,
    output logic [AW:0]   count,
    output logic          underflow_err
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push, pop;

    // in_ready depends only on count, so input_grant never reaches it combinationally
    assign in_ready = count != (AW+1)'(DEPTH);
    assign d_valid  = count != '0;
    assign push     = in_valid && in_ready;
    assign pop      = input_grant && d_valid;
    assign d        = d_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (input_grant && !d_valid) underflow_err <= 1'b1;
        end
    end
endmodule
